// File: rtl/apb_rr_master.sv
// APB master that shares one slave between NUM_REQ requesters.
// Round-robin arbitration, SETUP/ACCESS sequencing and an ACCESS-phase timeout.
module apb_rr_master #(
  parameter int NUM_REQ     = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_tmo,
  output logic                  busy,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [AW-1:0]         paddr,
  output logic [DW-1:0]         pwdata,
  input  logic [DW-1:0]         prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic                 armed_r, armed_s;
  logic [PW-1:0]        gnt_r, gnt_s, rr_ptr_r, rr_ptr_s, pick_s;
  logic [CW-1:0]        tmo_cnt_r, tmo_cnt_s;
  logic                 psel_s, penable_s, pwrite_s, busy_s;
  logic                 rsp_err_s, rsp_tmo_s, finish_s;
  logic [AW-1:0]        paddr_s;
  logic [DW-1:0]        pwdata_s, rsp_rdata_s;
  logic [NUM_REQ-1:0]   req_done_s;

  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [PW-1:0]      ptr);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && v[idx]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign pick_s = rr_pick(req_valid, rr_ptr_r);

  // Next-state and next-output computation; armed_r marks a winner latched in IDLE
  always_comb begin
    state_s     = state_r;
    armed_s     = armed_r;
    gnt_s       = gnt_r;
    rr_ptr_s    = rr_ptr_r;
    tmo_cnt_s   = tmo_cnt_r;
    psel_s      = psel;
    penable_s   = penable;
    pwrite_s    = pwrite;
    paddr_s     = paddr;
    pwdata_s    = pwdata;
    busy_s      = busy;
    req_done_s  = '0;
    rsp_rdata_s = '0;
    rsp_err_s   = 1'b0;
    rsp_tmo_s   = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (armed_r) begin
          state_s   = SETUP;
          armed_s   = 1'b0;
          psel_s    = 1'b1;
          penable_s = 1'b0;
          busy_s    = 1'b1;
        end else if (|req_valid) begin
          armed_s  = 1'b1;
          gnt_s    = pick_s;
          pwrite_s = req_write[pick_s];
          paddr_s  = req_addr[int'(pick_s)*AW +: AW];
          pwdata_s = req_wdata[int'(pick_s)*DW +: DW];
        end else begin
          armed_s = 1'b0;
        end
      end
      SETUP: begin
        state_s   = ACCESS;
        penable_s = 1'b1;
        tmo_cnt_s = '0;
      end
      ACCESS: begin
        if (pready) begin
          finish_s    = 1'b1;
          rsp_err_s   = pslverr;
          rsp_rdata_s = (pslverr || pwrite) ? '0 : prdata;
        end else if (tmo_cnt_r == CW'(TIMEOUT_CYC - 1)) begin
          finish_s  = 1'b1;
          rsp_err_s = 1'b1;
          rsp_tmo_s = 1'b1;
        end else begin
          tmo_cnt_s = tmo_cnt_r + CW'(1);
        end
      end
      default: begin
        state_s   = IDLE;
        armed_s   = 1'b0;
        psel_s    = 1'b0;
        penable_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
    if (finish_s) begin
      state_s            = IDLE;
      psel_s             = 1'b0;
      penable_s          = 1'b0;
      busy_s             = 1'b0;
      tmo_cnt_s          = '0;
      req_done_s[gnt_r]  = 1'b1;
      rr_ptr_s           = (gnt_r == PW'(NUM_REQ - 1)) ? '0 : gnt_r + PW'(1);
    end else begin
      rr_ptr_s = rr_ptr_r;
    end
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_r   <= IDLE;
      armed_r   <= 1'b0;
      gnt_r     <= '0;
      rr_ptr_r  <= '0;
      tmo_cnt_r <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      busy      <= 1'b0;
      req_done  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_tmo   <= 1'b0;
    end else begin
      state_r   <= state_s;
      armed_r   <= armed_s;
      gnt_r     <= gnt_s;
      rr_ptr_r  <= rr_ptr_s;
      tmo_cnt_r <= tmo_cnt_s;
      psel      <= psel_s;
      penable   <= penable_s;
      pwrite    <= pwrite_s;
      paddr     <= paddr_s;
      pwdata    <= pwdata_s;
      busy      <= busy_s;
      req_done  <= req_done_s;
      rsp_rdata <= rsp_rdata_s;
      rsp_err   <= rsp_err_s;
      rsp_tmo   <= rsp_tmo_s;
    end
  end

endmodule
